// File: rtl/pipe_register_pkg.sv
// Shared constants and width helpers for the pipe_register elastic pipeline.
package pipe_register_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;

  // Ceiling log2 that never returns 0, so a derived width is always legal.
  function automatic int clog2_safe(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Wide enough for DEPTH stages plus the optional skid entry.
  function automatic int occupancy_width(input int depth);
    return clog2_safe(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One pipeline stage: a valid bit plus a data word, loaded when the stage is ready.
module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int                   BIT_WIDTH   = DEFAULT_BIT_WIDTH,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 src_valid,
  input  logic [BIT_WIDTH-1:0] src_data,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] data
);

  logic                 valid_reg;
  logic [BIT_WIDTH-1:0] data_reg;

  // A bubble moving in clears the valid bit but keeps the old data word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VALUE;
    end else if (load) begin
      valid_reg <= src_valid;
      if (src_valid) begin
        data_reg <= src_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_register.sv
// DEPTH-stage elastic register pipeline with valid/ready at both ends and occupancy.
// Define PIPE_REGISTER_SKID_EN to add a one-entry input skid buffer (registered in_ready).
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int                   BIT_WIDTH   = DEFAULT_BIT_WIDTH,
  parameter int                   DEPTH       = 2,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   CNT_WIDTH   = occupancy_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] occupancy
);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_register: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     ready;
  logic [DEPTH-1:0]     src_valid;
  logic [BIT_WIDTH-1:0] src_data [DEPTH];
  logic [BIT_WIDTH-1:0] data     [DEPTH];
  logic                 stage0_valid;
  logic [BIT_WIDTH-1:0] stage0_data;
  logic                 in_accept;
  logic                 out_accept;
  logic [CNT_WIDTH-1:0] occupancy_reg;
  logic [CNT_WIDTH-1:0] occupancy_next;
  logic [CNT_WIDTH-1:0] held_count;

  // Ready ripples from the output back to stage 0 within one cycle.
  always_comb begin
    logic ready_acc;
    ready_acc = out_ready;
    ready     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_acc = !valid[i] || ready_acc;
      ready[i]  = ready_acc;
    end
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign src_valid[gi] = stage0_valid;
      assign src_data[gi]  = stage0_data;
    end else begin : g_body
      assign src_valid[gi] = valid[gi-1];
      assign src_data[gi]  = data[gi-1];
    end

    pipe_register_stage #(
      .BIT_WIDTH   (BIT_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ready[gi]),
      .src_valid (src_valid[gi]),
      .src_data  (src_data[gi]),
      .valid     (valid[gi]),
      .data      (data[gi])
    );
  end

`ifdef PIPE_REGISTER_SKID_EN
  logic                 skid_valid_reg;
  logic [BIT_WIDTH-1:0] skid_data_reg;

  // A parked word always enters stage 0 before anything new from upstream.
  assign in_ready     = !skid_valid_reg;
  assign stage0_valid = skid_valid_reg || in_valid;
  assign stage0_data  = skid_valid_reg ? skid_data_reg : in_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= RESET_VALUE;
    end else if (skid_valid_reg) begin
      if (ready[0]) begin
        skid_valid_reg <= 1'b0;
      end
    end else if (in_valid && !ready[0]) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
    end
  end

  assign held_count = CNT_WIDTH'($countones(valid)) + CNT_WIDTH'(skid_valid_reg);
`else
  assign in_ready     = ready[0];
  assign stage0_valid = in_valid;
  assign stage0_data  = in_data;
  assign held_count   = CNT_WIDTH'($countones(valid));
`endif

  assign out_valid  = valid[DEPTH-1];
  assign out_data   = data[DEPTH-1];
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  always_comb begin
    occupancy_next = occupancy_reg;
    case ({in_accept, out_accept})
      2'b10:   occupancy_next = occupancy_reg + CNT_WIDTH'(1);
      2'b01:   occupancy_next = occupancy_reg - CNT_WIDTH'(1);
      default: occupancy_next = occupancy_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  assign occupancy = occupancy_reg;

  // The running count must always match the number of words actually held.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (occupancy_reg == held_count);
    end
  end

endmodule
